// File: rtl/popcount_pkg.sv
// popcount_pkg: shared encodings for the sequential population counter.
// Build option: define POPCOUNT_SEQ_PARITY_EN to add the parity output on popcount_seq.
package popcount_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operand interpretation selected by the mode input
  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

endpackage : popcount_pkg

// File: rtl/chunk_popcount.sv
// chunk_popcount: combinational count of set bits in a CHUNK-bit slice.
// Output is sized to hold CHUNK itself, so it never wraps.
module chunk_popcount #(
  parameter int CHUNK = 8,
  localparam int OW   = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [OW-1:0]    ones
);

  // Ripple sum of the individual bits; synthesis rebalances this into an adder tree
  always_comb begin
    ones = '0;
    for (int i = 0; i < CHUNK; i++) begin
      ones = ones + OW'(bits[i]);
    end
  end

endmodule : chunk_popcount

// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population counter with start/busy/done handshake.
// Consumes CHUNK bits of the latched operand per RUN cycle, low chunk first.
// Build option: define POPCOUNT_SEQ_PARITY_EN to add a 'parity' output (count[0]).
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  CHUNK = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
`ifdef POPCOUNT_SEQ_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int BEATS = WIDTH / CHUNK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW    = $clog2(CHUNK + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Reject operand/chunk combinations that cannot be split evenly
  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("popcount_seq: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    acc_reg,   acc_next;
  logic [BW-1:0]    beat_reg,  beat_next;
  logic             mode_reg,  mode_next;
  logic [CW-1:0]    count_reg, count_next;
`ifdef POPCOUNT_SEQ_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic [CHUNK-1:0] chunk_bits;
  logic [OW-1:0]    chunk_ones;
  logic [CW-1:0]    acc_sum;

  // Counting zeros is counting ones of the inverted slice
  assign chunk_bits = (mode_reg == MODE_ONES) ? shreg_reg[CHUNK-1:0] : ~shreg_reg[CHUNK-1:0];

  chunk_popcount #(.CHUNK(CHUNK)) u_chunk (
    .bits (chunk_bits),
    .ones (chunk_ones)
  );

  // Running total including the current slice; CW bits always hold WIDTH
  assign acc_sum = acc_reg + CW'(chunk_ones);

  // State register; an asserted reset abandons any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath next values; new work is accepted from IDLE and DONE alike
  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    acc_next    = acc_reg;
    beat_next   = beat_reg;
    mode_next   = mode_reg;
    count_next  = count_reg;
`ifdef POPCOUNT_SEQ_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          shreg_next = data;
          mode_next  = mode;
          acc_next   = '0;
          beat_next  = '0;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_next   = acc_sum;
        shreg_next = shreg_reg >> CHUNK;
        beat_next  = beat_reg + BW'(1);
        if (beat_reg == LAST_BEAT) begin
          count_next  = acc_sum;
`ifdef POPCOUNT_SEQ_PARITY_EN
          parity_next = acc_sum[0];
`endif
          state_next  = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers; count only changes on RUN->DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_reg  <= '0;
      acc_reg    <= '0;
      beat_reg   <= '0;
      mode_reg   <= MODE_ONES;
      count_reg  <= '0;
`ifdef POPCOUNT_SEQ_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      shreg_reg  <= shreg_next;
      acc_reg    <= acc_next;
      beat_reg   <= beat_next;
      mode_reg   <= mode_next;
      count_reg  <= count_next;
`ifdef POPCOUNT_SEQ_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  assign ready  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign busy   = (state_reg == ST_RUN);
  assign done   = (state_reg == ST_DONE);
  assign count  = count_reg;
`ifdef POPCOUNT_SEQ_PARITY_EN
  assign parity = parity_reg;
`endif

endmodule : popcount_seq

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: directed checks of popcount_seq (CHUNK=8 and CHUNK=32 builds).
module tb_popcount_seq;
  import popcount_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start32 = 1'b0;
  logic        mode = MODE_ONES;
  logic [31:0] data = '0;

  logic        ready, busy, done;
  logic [5:0]  count;
  logic        ready32, busy32, done32;
  logic [5:0]  count32;
`ifdef POPCOUNT_SEQ_PARITY_EN
  logic        parity, parity32;
`endif

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  popcount_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .data   (data),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .count  (count)
`ifdef POPCOUNT_SEQ_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  popcount_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk    (clk),
    .reset  (reset),
    .start  (start32),
    .mode   (mode),
    .data   (data),
    .ready  (ready32),
    .busy   (busy32),
    .done   (done32),
    .count  (count32)
`ifdef POPCOUNT_SEQ_PARITY_EN
    ,
    .parity (parity32)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accept an operation at the next edge, then follow it through 4 busy cycles to done
  task automatic run_op(input string tag, input logic [31:0] d, input logic m,
                        input logic [5:0] exp_cnt, input logic [5:0] prev_cnt);
    data  = d;
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " no_done"}, 32'(done), 32'd0);
      chk({tag, " count_held"}, 32'(count), 32'(prev_cnt));
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " count"}, 32'(count), 32'(exp_cnt));
    chk({tag, " ready_done"}, 32'(ready), 32'd1);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " ready_idle"}, 32'(ready), 32'd1);
    chk({tag, " count_keep"}, 32'(count), 32'(exp_cnt));
    $display("op %s data=%08h mode=%0d count=%0d", tag, d, m, count);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst count32", 32'(count32), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic count: 4+4+1 ones
    run_op("t1", 32'hF0F0_0001, MODE_ONES, 6'd9, 6'd0);

    // Held start during RUN is ignored, then accepted in the DONE cycle
    data  = 32'h0000_00FF;
    mode  = MODE_ONES;
    start = 1'b1;
    @(negedge clk);
    data = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      chk("b2b busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("b2b done1", 32'(done), 32'd1);
    chk("b2b count1", 32'(count), 32'd8);
    @(negedge clk);
    start = 1'b0;
    chk("b2b no_bubble", 32'(busy), 32'd1);
    chk("b2b ready_run", 32'(ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("b2b count_held", 32'(count), 32'd8);
    @(negedge clk);
    chk("b2b done2", 32'(done), 32'd1);
    chk("b2b count2", 32'(count), 32'd0);
    $display("op b2b first=8 second=%0d", count);
    @(negedge clk);

    // Zero counting and full-scale results
    run_op("zeros", 32'h0000_0000, MODE_ZEROS, 6'd32, 6'd0);
    run_op("ones_max", 32'hFFFF_FFFF, MODE_ONES, 6'd32, 6'd32);

    // Reset in the second RUN cycle aborts immediately
    data  = 32'h0F0F_0F0F;
    mode  = MODE_ONES;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort count", 32'(count), 32'd0);
    chk("abort ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort no_done", 32'(done), 32'd0);
    end
    $display("op abort count=%0d", count);
    run_op("post_rst", 32'h8000_0000, MODE_ONES, 6'd1, 6'd0);

    // Single-beat build: done two edges after accept
    data    = 32'h1234_5678;
    mode    = MODE_ONES;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("c32 busy", 32'(busy32), 32'd1);
    chk("c32 no_done", 32'(done32), 32'd0);
    @(negedge clk);
    chk("c32 done", 32'(done32), 32'd1);
    chk("c32 count", 32'(count32), 32'd13);
`ifdef POPCOUNT_SEQ_PARITY_EN
    chk("c32 parity", 32'(parity32), 32'd1);
    chk("main parity", 32'(parity), 32'd1);
`endif
    $display("op c32 data=%08h count=%0d", data, count32);
    @(negedge clk);
    chk("c32 done_pulse", 32'(done32), 32'd0);
    chk("c32 count_keep", 32'(count32), 32'd13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_popcount_seq

// File: doc/popcount_seq.md
Name: popcount_seq

Overview:
- Parametrised multi-cycle population counter. It is the next generation of the 8-bit combinational bit adder.
- Counts set bits (or clear bits, selected by mode) in a WIDTH-bit operand, CHUNK bits per cycle.
- Uses a start/busy/done handshake. It sits beside the ALU/MDU as a long-latency unit for count-style instructions.
- The result is held until the next completed operation.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK; elaboration fails otherwise.
- CHUNK, 8, bits consumed per RUN cycle. Allowed range 1..WIDTH.
- CW, $clog2(WIDTH+1), result width. Derived; not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request; sampled on the rising edge, accepted only when ready=1.
- mode  in  1  0 = count ones; 1 = count zeros. Latched on accept.
- data  in  WIDTH  operand. Latched on accept.
- ready  out  1  1 in IDLE and DONE states.
- busy  out  1  1 in RUN state.
- done  out  1  single-cycle pulse: result valid this cycle.
- count  out  CW  last completed result; held between operations.

Behaviour:
- Reset values (async, reset=0): state=IDLE, shreg=0, acc=0, beat=0, count=0, busy=0, done=0, ready=1.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 -> shreg<=data, mode_q<=mode, acc<=0, beat<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle: acc <= acc + popcount(mode_q ? ~shreg[CHUNK-1:0] : shreg[CHUNK-1:0]).
  - Shift: shreg <= shreg >> CHUNK. beat <= beat+1.
  - On beat == WIDTH/CHUNK-1: count <= final acc (including this chunk), go to DONE.
  - start is ignored in RUN; no queueing. data and mode changes are ignored.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 -> accept a new operation exactly as in IDLE and go to RUN (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0 -> done=1 in the cycle after edge E(WIDTH/CHUNK). For WIDTH=32, CHUNK=8: done is high in cycle 5 counting E0 as edge 0; count is valid in the same cycle.
- Throughput: one result per WIDTH/CHUNK+1 cycles. Back-to-back starts give one per WIDTH/CHUNK+1.
- Width rules:
  - acc is CW bits and never overflows, since the maximum is WIDTH.
  - Chunk popcount is $clog2(CHUNK+1) bits, zero-extended before the add.
- CHUNK=WIDTH: single RUN cycle; latency 2 edges.
- count is only written on RUN->DONE; otherwise it keeps the last result across IDLE and new RUNs.
- Reset mid-RUN aborts immediately: no done pulse, count=0.

Optional Feature:
- Macro POPCOUNT_SEQ_PARITY_EN.
- Defined: extra output port parity (1 bit, reset 0). It is updated with count on RUN->DONE and equals count[0]. It reflects odd/even for the selected mode and is held like count.
- Undefined: the port and its logic are absent; everything else is identical.

Decomposition:
- Shared package/header popcount_pkg:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - mode constants MODE_ONES=1'b0, MODE_ZEROS=1'b1.
- One sub-module, chunk_popcount #(CHUNK): combinational, in [CHUNK-1:0] -> out [$clog2(CHUNK+1)-1:0]. It is the parametrised successor of the 8-bit bit adder and is instantiated once in the datapath.

Test Plan:
- WIDTH=32, CHUNK=8, data=32'hF0F0_0001, mode=0, start 1 cycle -> busy for 4 cycles, done pulse 5 cycles after accept, count=9, ready=1 after.
- mode=1, data=32'h0000_0000 -> count=32. Then mode=0, data=32'hFFFF_FFFF -> count=32 (6-bit max, no wrap).
- start=1 held throughout RUN with data=0 -> ignored. In the DONE cycle the held start is accepted immediately and the next result is 0 (back-to-back, no IDLE cycle).
- reset pulled low in the 2nd RUN cycle -> all outputs 0 asynchronously, no done. After release, a fresh start with 32'h8000_0000 gives count=1.
- CHUNK=32 build, data=32'h1234_5678 -> done 2 edges after accept, count=13. With POPCOUNT_SEQ_PARITY_EN, parity=1.
